simd_alu_pipe: RTL and testbench

Pipelined, parametrised successor to the datapath ALU: a WIDTH-bit SIMD integer unit whose operand word is partitioned at run time into 1, 2 or 4 independent lanes. It adds signed/unsigned saturating add/sub and per-lane MIN/MAX, and produces per-lane compare flags. A two-stage valid/ready pipeline gives full throughput under backpressure. It sits between the issue stage and writeback.

---
 rtl/simd_alu_pkg.sv | 68 ++++++
 rtl/simd_lane_adder.sv | 37 +++
 rtl/simd_alu_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// Shared types and lane helpers for the SIMD ALU pipeline.
// The operand word is split into four quarters; a lane is one, two or four
// quarters depending on lane mode. Helpers map quarters and lanes onto each other.
package simd_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_ADDS_S = 4'd8,
    OP_SUBS_S = 4'd9,
    OP_ADDS_U = 4'd10,
    OP_SUBS_U = 4'd11,
    OP_MIN_S  = 4'd12,
    OP_MAX_S  = 4'd13,
    OP_MIN_U  = 4'd14,
    OP_MAX_U  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    MODE_1X   = 2'd0,
    MODE_2X   = 2'd1,
    MODE_4X   = 2'd2,
    MODE_RSVD = 2'd3
  } lane_mode_e;

  // Bit k set: carry must not propagate from quarter k into quarter k+1.
  function automatic logic [2:0] carry_break_mask(input lane_mode_e mode);
    case (mode)
      MODE_2X: return 3'b010;
      MODE_4X: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Bit i set: lane i exists in this mode.
  function automatic logic [3:0] lane_valid_mask(input lane_mode_e mode);
    case (mode)
      MODE_2X: return 4'b0011;
      MODE_4X: return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // Most-significant quarter of the lane that contains quarter q.
  function automatic logic [1:0] lane_top(input lane_mode_e mode, input logic [1:0] q);
    case (mode)
      MODE_2X: return {q[1], 1'b1};
      MODE_4X: return q;
      default: return 2'b11;
    endcase
  endfunction

  // Most-significant quarter of lane number `lane` (meaningless for absent lanes).
  function automatic logic [1:0] lane_msq(input lane_mode_e mode, input logic [1:0] lane);
    case (mode)
      MODE_2X: return {lane[0], 1'b1};
      MODE_4X: return lane;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// WIDTH-bit adder/subtractor built from four quarter adders with carry kill at
// the quarter boundaries named in carry_break.
// Ports: a, b operands; sub selects a-b (b inverted, carry-in 1 at every lane
// start); sum result; carry_out / overflow per quarter (valid at lane tops).
module simd_lane_adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [2:0]       carry_break,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       carry_out,
  output logic [3:0]       overflow
);

  localparam int unsigned Q = WIDTH / 4;

  logic [WIDTH-1:0] bx;
  logic [3:0]       cin;

  assign bx     = sub ? ~b : b;
  assign cin[0] = sub;

  for (genvar g = 0; g < 4; g++) begin : g_quarter
    logic [Q:0] s;
    assign s = {1'b0, a[g*Q +: Q]} + {1'b0, bx[g*Q +: Q]} + {{Q{1'b0}}, cin[g]};
    assign sum[g*Q +: Q] = s[Q-1:0];
    assign carry_out[g]  = s[Q];
    assign overflow[g]   = (a[g*Q+Q-1] == bx[g*Q+Q-1]) && (s[Q-1] != a[g*Q+Q-1]);
    if (g < 3) begin : g_chain
      // A broken boundary restarts the next lane with the subtract carry-in.
      assign cin[g+1] = carry_break[g] ? sub : s[Q];
    end
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage valid/ready SIMD integer ALU with 1, 2 or 4 lanes selected per op.
// Ports: clk, rst (async high); in_valid/in_ready with a, b, lane_mode, op;
// out_valid/out_ready with result and per-lane eq/slt/ult flags.
// S1 registers operands and decoded control; S2 registers result and flags.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned LANES_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       lane_mode,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [LANES_MAX-1:0] eq,
  output logic [LANES_MAX-1:0] slt,
  output logic [LANES_MAX-1:0] ult
);

  localparam int unsigned Q    = WIDTH / 4;
  localparam int unsigned H    = WIDTH / 2;
  localparam int unsigned SH_F = $clog2(WIDTH);
  localparam int unsigned SH_H = $clog2(H);
  localparam int unsigned SH_Q = $clog2(Q);

  // Pipeline control
  logic adv1, adv2;
  logic s1_valid, s2_valid;

  logic [WIDTH-1:0] s1_a, s1_b;
  op_e              s1_op;
  lane_mode_e       s1_mode;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_mode  <= MODE_1X;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_op   <= op_e'(op);
        s1_mode <= (lane_mode == 2'd3) ? MODE_1X : lane_mode_e'(lane_mode);
      end
    end
  end

  // S2 combinational datapath
  logic             add_sub;
  logic [2:0]       brk;
  logic [WIDTH-1:0] add_sum, cmp_sum;
  logic [3:0]       add_co, add_ov, cmp_co, cmp_ov;

  assign add_sub = (s1_op == OP_SUB) || (s1_op == OP_SUBS_S) || (s1_op == OP_SUBS_U);
  assign brk     = carry_break_mask(s1_mode);

  simd_lane_adder #(.WIDTH(WIDTH)) u_add (
    .a(s1_a), .b(s1_b), .sub(add_sub), .carry_break(brk),
    .sum(add_sum), .carry_out(add_co), .overflow(add_ov)
  );

  // Always-subtracting copy: compare flags and MIN/MAX come from a-b.
  simd_lane_adder #(.WIDTH(WIDTH)) u_cmp (
    .a(s1_a), .b(s1_b), .sub(1'b1), .carry_break(brk),
    .sum(cmp_sum), .carry_out(cmp_co), .overflow(cmp_ov)
  );

  logic [3:0] a_msb, cmp_msb, qeq;
  for (genvar g = 0; g < 4; g++) begin : g_qinfo
    assign a_msb[g]   = s1_a[g*Q+Q-1];
    assign cmp_msb[g] = cmp_sum[g*Q+Q-1];
    assign qeq[g]     = (cmp_sum[g*Q +: Q] == '0);
  end

  // Shifts per mode; lanes never exchange bits.
  logic [WIDTH-1:0] f_sll, f_srl, f_sra, h_sll, h_srl, h_sra, q_sll, q_srl, q_sra;
  logic [WIDTH-1:0] sh_l, sh_r, sh_a;

  assign f_sll = s1_a << s1_b[SH_F-1:0];
  assign f_srl = s1_a >> s1_b[SH_F-1:0];
  assign f_sra = $unsigned($signed(s1_a) >>> s1_b[SH_F-1:0]);

  for (genvar g = 0; g < 2; g++) begin : g_hshift
    assign h_sll[g*H +: H] = s1_a[g*H +: H] << s1_b[g*H +: SH_H];
    assign h_srl[g*H +: H] = s1_a[g*H +: H] >> s1_b[g*H +: SH_H];
    assign h_sra[g*H +: H] = $unsigned($signed(s1_a[g*H +: H]) >>> s1_b[g*H +: SH_H]);
  end

  for (genvar g = 0; g < 4; g++) begin : g_qshift
    assign q_sll[g*Q +: Q] = s1_a[g*Q +: Q] << s1_b[g*Q +: SH_Q];
    assign q_srl[g*Q +: Q] = s1_a[g*Q +: Q] >> s1_b[g*Q +: SH_Q];
    assign q_sra[g*Q +: Q] = $unsigned($signed(s1_a[g*Q +: Q]) >>> s1_b[g*Q +: SH_Q]);
  end

  always_comb begin
    sh_l = f_sll;
    sh_r = f_srl;
    sh_a = f_sra;
    case (s1_mode)
      MODE_2X: begin
        sh_l = h_sll;
        sh_r = h_srl;
        sh_a = h_sra;
      end
      MODE_4X: begin
        sh_l = q_sll;
        sh_r = q_srl;
        sh_a = q_sra;
      end
      default: ;
    endcase
  end

  // Per-quarter result select; lane-wide decisions use the lane's top quarter.
  logic [WIDTH-1:0] res_d;

  for (genvar g = 0; g < 4; g++) begin : g_res
    logic [1:0]   t;
    logic         is_top, lslt, lult;
    logic [Q-1:0] aq, bq, sq, sat_s, rq;

    assign t      = lane_top(s1_mode, 2'(g));
    assign is_top = (t == 2'(g));
    assign aq     = s1_a[g*Q +: Q];
    assign bq     = s1_b[g*Q +: Q];
    assign sq     = add_sum[g*Q +: Q];
    assign lslt   = cmp_msb[t] ^ cmp_ov[t];
    assign lult   = ~cmp_co[t];
    // Signed clamp toward the sign of a: top quarter carries the sign bit.
    assign sat_s  = is_top ? {a_msb[t], {(Q-1){~a_msb[t]}}} : {Q{~a_msb[t]}};

    always_comb begin
      rq = sq;
      case (s1_op)
        OP_ADD, OP_SUB:       rq = sq;
        OP_AND:               rq = aq & bq;
        OP_OR:                rq = aq | bq;
        OP_XOR:               rq = aq ^ bq;
        OP_SLL:               rq = sh_l[g*Q +: Q];
        OP_SRL:               rq = sh_r[g*Q +: Q];
        OP_SRA:               rq = sh_a[g*Q +: Q];
        OP_ADDS_S, OP_SUBS_S: rq = add_ov[t] ? sat_s : sq;
        OP_ADDS_U:            rq = add_co[t] ? '1 : sq;
        OP_SUBS_U:            rq = add_co[t] ? sq : '0;
        OP_MIN_S:             rq = lslt ? aq : bq;
        OP_MAX_S:             rq = lslt ? bq : aq;
        OP_MIN_U:             rq = lult ? aq : bq;
        OP_MAX_U:             rq = lult ? bq : aq;
        default:              rq = sq;
      endcase
    end

    assign res_d[g*Q +: Q] = rq;
  end

  // Per-lane flags
  logic [3:0] eq_raw, slt_raw, ult_raw, lane_mask;

  for (genvar gl = 0; gl < 4; gl++) begin : g_lane
    logic [1:0] lt;
    logic [3:0] member;
    assign lt = lane_msq(s1_mode, 2'(gl));
    for (genvar gm = 0; gm < 4; gm++) begin : g_member
      assign member[gm] = (lane_top(s1_mode, 2'(gm)) == lt);
    end
    assign eq_raw[gl]  = &(qeq | ~member);
    assign slt_raw[gl] = cmp_msb[lt] ^ cmp_ov[lt];
    assign ult_raw[gl] = ~cmp_co[lt];
  end

  assign lane_mask = lane_valid_mask(s1_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      eq       <= '0;
      slt      <= '0;
      ult      <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_d;
        eq     <= eq_raw  & lane_mask;
        slt    <= slt_raw & lane_mask;
        ult    <= ult_raw & lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
module tb_simd_alu_pipe;
  import simd_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic [1:0]  lane_mode;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  eq, slt, ult;

  int checks = 0;
  int errors = 0;

  simd_alu_pipe #(.WIDTH(64), .LANES_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .lane_mode(lane_mode), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .eq(eq), .slt(slt), .ult(ult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op at the current negedge; return at the negedge after acceptance.
  task automatic send(input logic [63:0] va, input logic [63:0] vb,
                      input logic [1:0] m, input logic [3:0] o);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; a = va; b = vb; lane_mode = m; op = o;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                        input logic [1:0] m, input logic [3:0] o, input logic [63:0] er,
                        input logic [3:0] ee, input logic [3:0] es, input logic [3:0] eu);
    out_ready = 1'b1;
    send(va, vb, m, o);
    chk({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_eq"},  {60'b0, eq},  {60'b0, ee});
    chk({tag, "_slt"}, {60'b0, slt}, {60'b0, es});
    chk({tag, "_ult"}, {60'b0, ult}, {60'b0, eu});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; lane_mode = 2'd0; op = OP_ADD;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {52'b0, eq, slt, ult}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    run_op("m0_add", 64'hA, 64'h5, 2'd0, OP_ADD, 64'hF, 4'b0000, 4'b0000, 4'b0000);
    run_op("m1_add_nocarry", 64'hFFFFFFFF_00000001, 64'h00000001_FFFFFFFF, 2'd1, OP_ADD,
           64'h0, 4'b0000, 4'b0010, 4'b0001);
    run_op("m2_adds_s", 64'h7FFF_8000_0001_1234, 64'h0001_FFFF_0001_0000, 2'd2, OP_ADDS_S,
           64'h7FFF_8000_0002_1234, 4'b0010, 4'b0100, 4'b0100);
    run_op("m2_subs_u", 64'h0, 64'h0001_0001_0001_0001, 2'd2, OP_SUBS_U,
           64'h0, 4'b0000, 4'b1111, 4'b1111);
    run_op("m2_sra", 64'h8000_8000_8000_8000, 64'h0004_0004_0004_0004, 2'd2, OP_SRA,
           64'hF800_F800_F800_F800, 4'b0000, 4'b1111, 4'b0000);
    run_op("m2_min_s", 64'h8000_8000_8000_8000, 64'h0001_0001_0001_0001, 2'd2, OP_MIN_S,
           64'h8000_8000_8000_8000, 4'b0000, 4'b1111, 4'b0000);
    run_op("m3_as_m0_add", 64'h00000000_FFFFFFFF, 64'h1, 2'd3, OP_ADD,
           64'h00000001_00000000, 4'b0000, 4'b0000, 4'b0000);
    run_op("m1_subs_s", 64'h80000000_00000005, 64'h00000001_00000003, 2'd1, OP_SUBS_S,
           64'h80000000_00000002, 4'b0000, 4'b0010, 4'b0000);
    run_op("m2_adds_u", 64'hFFFF_0001_8000_0000, 64'h0001_0001_8000_0000, 2'd2, OP_ADDS_U,
           64'hFFFF_0002_FFFF_0000, 4'b0111, 4'b1000, 4'b0000);
    run_op("m1_sll", 64'h00000001_80000001, 64'h00000021_00000001, 2'd1, OP_SLL,
           64'h00000002_00000002, 4'b0000, 4'b0011, 4'b0010);
    run_op("m0_srl", 64'h8000_0000_0000_0000, 64'h3F, 2'd0, OP_SRL,
           64'h1, 4'b0000, 4'b0001, 4'b0000);
    run_op("m2_max_u", 64'h0001_FFFF_0000_1234, 64'hFFFF_0001_0000_1000, 2'd2, OP_MAX_U,
           64'hFFFF_FFFF_0000_1234, 4'b0010, 4'b0100, 4'b1000);
    run_op("m1_xor", 64'hF0F0F0F0_0F0F0F0F, 64'hFFFFFFFF_FFFFFFFF, 2'd1, OP_XOR,
           64'h0F0F0F0F_F0F0F0F0, 4'b0000, 4'b0010, 4'b0011);

    // Backpressure: four ops, consumer stalled, then released.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 64'd11; b = 64'd1; lane_mode = 2'd0; op = OP_ADD;
    @(negedge clk);
    chk("bp_ready_after1", {63'b0, in_ready}, 64'd1);
    a = 64'd21; b = 64'd2;
    @(negedge clk);
    chk("bp_ready_full", {63'b0, in_ready}, 64'd0);
    chk("bp_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_hold0", result, 64'd12);
    a = 64'd31; b = 64'd3;
    @(negedge clk);
    chk("bp_hold1", result, 64'd12);
    chk("bp_ready_still0", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    chk("bp_hold2", result, 64'd12);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_drain", {63'b0, in_ready}, 64'd1);
    chk("bp_out0", result, 64'd12);
    @(negedge clk);
    chk("bp_out1_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_out1", result, 64'd23);
    a = 64'd41; b = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out2_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_out2", result, 64'd34);
    @(negedge clk);
    chk("bp_out3_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_out3", result, 64'd45);
    @(negedge clk);
    chk("bp_empty", {63'b0, out_valid}, 64'd0);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 64'd100; b = 64'd5; lane_mode = 2'd0; op = OP_ADD;
    @(negedge clk);
    a = 64'd200;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2_full_ready", {63'b0, in_ready}, 64'd0);
    chk("rst2_full_valid", {63'b0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst2_async_valid", {63'b0, out_valid}, 64'd0);
    chk("rst2_async_result", result, 64'd0);
    chk("rst2_async_flags", {52'b0, eq, slt, ult}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_discarded", {63'b0, out_valid}, 64'd0);
    chk("rst2_ready", {63'b0, in_ready}, 64'd1);
    run_op("post_rst_sub", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005, 2'd0, OP_SUB,
           64'hFFFF_FFFF_FFFF_FFFE, 4'b0000, 4'b0001, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
